// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with MTHI/MTLO writes and decode stall
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             hilo_rd,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    input  logic [WIDTH-1:0] hilo_wd,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_p;
    logic [WIDTH-1:0]   r_a, r_opa;
    logic               r_div, r_neg_q, r_neg_r, r_dz;
    logic               w_sgn, w_dge;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_drem, w_quo, w_rem, w_hi, w_lo;
    logic [WIDTH:0]     w_msum, w_dsh;
    logic [2*WIDTH-1:0] w_step, w_prod;
    assign stall   = busy & (start | hilo_rd);
    assign w_sgn   = ~op[0];
    assign w_abs_a = (w_sgn & opa[WIDTH-1]) ? -opa : opa;
    assign w_abs_b = (w_sgn & opb[WIDTH-1]) ? -opb : opb;
    // r_p holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    assign w_msum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    assign w_dsh   = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
    assign w_dge   = w_dsh >= {1'b0, r_a};
    assign w_drem  = w_dge ? WIDTH'(w_dsh - {1'b0, r_a}) : w_dsh[WIDTH-1:0];
    assign w_step  = r_div ? {w_drem, r_p[WIDTH-2:0], w_dge} : {w_msum, r_p[WIDTH-1:1]};
    assign w_prod  = r_neg_q ? -r_p : r_p;
    assign w_quo   = r_neg_q ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
    assign w_rem   = r_neg_r ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];
    assign w_hi    = r_div ? (r_dz ? r_opa : w_rem) : w_prod[2*WIDTH-1:WIDTH];
    assign w_lo    = r_div ? (r_dz ? {WIDTH{1'b1}} : w_quo) : w_prod[WIDTH-1:0];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (start && !flush) ? RUN : IDLE;
            RUN:     w_next = flush ? IDLE : (r_cnt == CW'(WIDTH-1)) ? FIX : RUN;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            r_cnt   <= '0;
            r_p     <= '0;
            r_a     <= '0;
            r_opa   <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            done <= 1'b0;
            busy <= (w_next != IDLE);
            if (r_state == IDLE) begin
                if (mthi_we) hi <= hilo_wd;
                if (mtlo_we) lo <= hilo_wd;
                if (start && !flush) begin
                    r_div   <= op[1];
                    r_cnt   <= '0;
                    r_a     <= op[1] ? w_abs_b : w_abs_a;
                    r_p     <= {{WIDTH{1'b0}}, op[1] ? w_abs_a : w_abs_b};
                    r_neg_q <= w_sgn & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                    r_neg_r <= w_sgn & op[1] & opa[WIDTH-1];
                    r_dz    <= op[1] & (opb == '0);
                    r_opa   <= opa;
                end
            end else if (r_state == RUN) begin
                r_p   <= w_step;
                r_cnt <= r_cnt + 1'b1;
            end else if (!flush) begin
                hi   <= w_hi;
                lo   <= w_lo;
                done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq (results, latency, stall, flush, MT writes, async reset)
module tb_muldiv_seq;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, hilo_rd = 1'b0;
    logic        mthi_we = 1'b0, mtlo_we = 1'b0, flush = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] opa = '0, opb = '0, hilo_wd = '0;
    logic [31:0] hi, lo;
    logic        busy, done, stall;
    logic [63:0] q_exp[$];
    int          n_run = 0, n_fail = 0;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
        .hilo_rd(hilo_rd), .mthi_we(mthi_we), .mtlo_we(mtlo_we), .hilo_wd(hilo_wd),
        .flush(flush), .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        if (o == 2'b00) return {{32{a[31]}}, a} * {{32{b[31]}}, b};
        if (o == 2'b01) return {32'b0, a} * {32'b0, b};
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (o == 2'b11) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        q_exp.push_back(model(o, a, b));
        op = o; opa = a; opb = b; start = 1'b1;
        step();
        start = 1'b0;
        check("busy_t0", busy, 1);
    endtask

    task automatic finish_op(input int n0);
        int n = n0;
        while (!done && n < 60) begin
            step();
            n++;
        end
        if (!done) begin
            check("done_timeout", done, 1);
            q_exp.delete();
        end else begin
            check("hilo", {hi, lo}, q_exp.pop_front());
            check("latency", n, 34);
            check("busy_end", busy, 0);
            step();
            check("done_pulse", done, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] ro;
        logic       seen;
        #1 rst = 1'b0;
        #2;
        check("rst_hilo", {hi, lo}, 64'h0);
        check("rst_flags", {busy, done, stall}, 3'b000);
        #19 rst = 1'b1;
        step();

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF); finish_op(1);
        issue(2'b00, -32'sd3, 32'd7);               finish_op(1);
        issue(2'b10, -32'sd7, 32'd2);               finish_op(1);
        issue(2'b10, 32'd7, -32'sd2);               finish_op(1);
        issue(2'b11, 32'd100, 32'd0);               finish_op(1);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF); finish_op(1);
        issue(2'b10, -32'sd5, 32'd0);               finish_op(1);
        issue(2'b00, 32'h8000_0000, 32'h8000_0000); finish_op(1);
        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(3, 0));
            issue(ro, $urandom, (i == 3) ? 32'($urandom_range(9, 1)) : $urandom);
            finish_op(1);
        end

        // decode hazards while busy: read stall and an ignored second start
        issue(2'b00, 32'd5, 32'd6);
        for (int n = 1; n < 10; n++) begin
            if (n == 5) hilo_rd = 1'b1;
            #1 check("stall_rd", stall, n >= 5);
            step();
        end
        op = 2'b11; opa = 32'd9; opb = 32'd2; start = 1'b1;
        #1 check("stall_start", stall, 1);
        step();
        start = 1'b0;
        finish_op(11);
        check("stall_idle", stall, 0);
        check("no_relaunch", busy, 0);
        hilo_rd = 1'b0;

        mtlo_we = 1'b1; hilo_wd = 32'h1234;
        step();
        mtlo_we = 1'b0;
        check("mtlo", {hi, lo}, {32'd0, 32'h1234});
        mthi_we = 1'b1; mtlo_we = 1'b1; hilo_wd = 32'hA5A5_A5A5;
        step();
        mthi_we = 1'b0; mtlo_we = 1'b0;
        check("mt_both", {hi, lo}, {2{32'hA5A5_A5A5}});

        // flushed divide leaves HI/LO alone and never pulses done
        op = 2'b11; opa = 32'd50; opb = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n < 13; n++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy", busy, 0);
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            seen |= done;
            step();
        end
        check("flush_no_done", seen, 0);
        check("flush_hilo", {hi, lo}, {2{32'hA5A5_A5A5}});
        start = 1'b1; flush = 1'b1;
        step();
        start = 1'b0; flush = 1'b0;
        check("flush_beats_start", busy, 0);
        issue(2'b11, 32'd50, 32'd3); finish_op(1);

        mtlo_we = 1'b1; hilo_wd = 32'h77;
        issue(2'b01, 32'd3, 32'd4);
        mtlo_we = 1'b0;
        check("mt_with_start", lo, 32'h77);
        mthi_we = 1'b1; hilo_wd = 32'hDEAD_BEEF;
        step();
        mthi_we = 1'b0;
        check("mt_busy_drop", hi, 32'd2);
        finish_op(2);

        issue(2'b00, 32'd123, 32'd456);
        q_exp.delete();
        for (int n = 1; n < 20; n++) step();
        #3 rst = 1'b0;
        #1;
        check("arst_hilo", {hi, lo}, 64'h0);
        check("arst_flags", {busy, done}, 2'b00);
        #2 rst = 1'b1;
        step();
        check("arst_idle", busy, 0);
        issue(2'b00, -32'sd3, 32'd7); finish_op(1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
